// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the mm:ss stopwatch core.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StPaused = 2'd1,
        StAdjust = 2'd2
    } sw_state_e;

    localparam int unsigned SEC_ONES_MAX = 9;
    localparam int unsigned SEC_TENS_MAX = 5;
    localparam int unsigned MIN_ONES_MAX = 9;

    function automatic int unsigned min_tens_lim(input int unsigned max_min);
        return max_min / 10;
    endfunction

    function automatic int unsigned min_ones_lim(input int unsigned max_min);
        return max_min % 10;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit: wraps to 0 above lim_i on increment, to Modulus-1 below 0 on decrement.
module bcd_digit #(
    parameter int unsigned Modulus = 10,
    parameter int unsigned Width   = 4
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             clr_i,
    input  logic [Width-1:0] lim_i,
    output logic [Width-1:0] q_o,
    output logic             carry_o,
    output logic             borrow_o
);

    localparam logic [Width-1:0] Top = Width'(Modulus - 1);

    logic [Width-1:0] q_q, q_d;

    assign carry_o  = inc_i && (q_q == lim_i);
    assign borrow_o = dec_i && (q_q == '0);
    assign q_o      = q_q;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (inc_i) begin
            q_d = carry_o ? '0 : q_q + Width'(1);
        end else if (dec_i) begin
            q_d = borrow_o ? Top : q_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// mm:ss up/down stopwatch with pause, lap hold, per-field adjust and countdown-done flag.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned MIN_TENS_W = 3,
    parameter int unsigned MAX_MIN    = 59
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  tick_i,
    input  logic                  adj_tick_i,
    input  logic                  pause_p_i,
    input  logic                  lap_p_i,
    input  logic                  adj_i,
    input  logic                  sel_i,
    input  logic                  down_i,
    output logic [MIN_TENS_W-1:0] min1_o,
    output logic [3:0]            min2_o,
    output logic [2:0]            sec1_o,
    output logic [3:0]            sec2_o,
    output logic                  running_o,
    output logic                  done_o,
    output logic                  wrap_o
);

    localparam int unsigned CntW = MIN_TENS_W + 11;
    localparam logic [MIN_TENS_W-1:0] MinTensLim = MIN_TENS_W'(min_tens_lim(MAX_MIN));
    localparam logic [3:0] MinOnesLim = 4'(min_ones_lim(MAX_MIN));

    sw_state_e state_q, state_d;
    logic hold_q, hold_d, done_q, done_d, wrap_q, wrap_d;
    logic [CntW-1:0] lap_q, lap_d, live;

    logic [3:0] so_q, mo_q;
    logic [2:0] st_q;
    logic [MIN_TENS_W-1:0] mt_q;

    logic cnt_en, up, dn, adj_en, adj_sec, adj_min;
    logic is_zero, next_zero, at_max_min, min_inc, min_clr;
    logic so_carry, st_carry, mo_carry, mt_carry;
    logic so_borrow, st_borrow, mo_borrow, mt_borrow;
    logic unused_flags;

    assign live       = {mt_q, mo_q, st_q, so_q};
    assign is_zero    = (live == '0);
    assign at_max_min = (mt_q == MinTensLim) && (mo_q == MinOnesLim);

    // A tick in the same cycle adj rises is dropped, even though state_q is still RUN.
    assign cnt_en  = tick_i && (state_q == StRun) && !adj_i;
    assign up      = cnt_en && !down_i;
    assign dn      = cnt_en && down_i && !is_zero;
    assign adj_en  = adj_tick_i && (state_q == StAdjust) && adj_i;
    assign adj_sec = adj_en && !sel_i;
    assign adj_min = adj_en && sel_i;

    assign next_zero = dn && (so_q == 4'd1) && (st_q == '0) && (mo_q == '0) && (mt_q == '0);

    // Seconds tens carry reaches the minutes only when counting, never in adjust.
    assign min_inc = (up && st_carry) || adj_min;
    assign min_clr = min_inc && at_max_min;

    bcd_digit #(.Modulus(SEC_ONES_MAX + 1), .Width(4)) u_sec_ones (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .inc_i    (up || adj_sec),
        .dec_i    (dn),
        .clr_i    (1'b0),
        .lim_i    (4'(SEC_ONES_MAX)),
        .q_o      (so_q),
        .carry_o  (so_carry),
        .borrow_o (so_borrow)
    );

    bcd_digit #(.Modulus(SEC_TENS_MAX + 1), .Width(3)) u_sec_tens (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .inc_i    (so_carry),
        .dec_i    (so_borrow),
        .clr_i    (1'b0),
        .lim_i    (3'(SEC_TENS_MAX)),
        .q_o      (st_q),
        .carry_o  (st_carry),
        .borrow_o (st_borrow)
    );

    bcd_digit #(.Modulus(MIN_ONES_MAX + 1), .Width(4)) u_min_ones (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .inc_i    (min_inc && !at_max_min),
        .dec_i    (st_borrow),
        .clr_i    (min_clr),
        .lim_i    (4'(MIN_ONES_MAX)),
        .q_o      (mo_q),
        .carry_o  (mo_carry),
        .borrow_o (mo_borrow)
    );

    bcd_digit #(.Modulus(min_tens_lim(MAX_MIN) + 1), .Width(MIN_TENS_W)) u_min_tens (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .inc_i    (mo_carry),
        .dec_i    (mo_borrow),
        .clr_i    (min_clr),
        .lim_i    (MinTensLim),
        .q_o      (mt_q),
        .carry_o  (mt_carry),
        .borrow_o (mt_borrow)
    );

    // The wrap to 00:00 is handled by min_clr, so the top digit never carries or borrows.
    assign unused_flags = mt_carry ^ mt_borrow;

    always_comb begin
        state_d = state_q;
        if (adj_i) begin
            state_d = StAdjust;
        end else begin
            unique case (state_q)
                StRun:    if (pause_p_i || next_zero) state_d = StPaused;
                StPaused: if (pause_p_i) state_d = StRun;
                StAdjust: state_d = StPaused;
                default:  state_d = StRun;
            endcase
        end

        hold_d = hold_q;
        if (adj_i || (state_q == StAdjust)) begin
            hold_d = 1'b0;
        end else if (lap_p_i) begin
            hold_d = !hold_q;
        end
        lap_d = (hold_d && !hold_q) ? live : lap_q;

        done_d = done_q;
        if (next_zero) begin
            done_d = 1'b1;
        end else if (up || dn || adj_en) begin
            done_d = 1'b0;
        end

        wrap_d = up && st_carry && at_max_min;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StRun;
            hold_q  <= 1'b0;
            lap_q   <= '0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            lap_q   <= lap_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign {min1_o, min2_o, sec1_o, sec2_o} = hold_q ? lap_q : live;
    assign running_o = (state_q == StRun);
    assign done_o    = done_q;
    assign wrap_o    = wrap_q;

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Parametrised mm:ss stopwatch/timer core, the successor to the stopwatch `Counter`. It counts BCD minutes and seconds on an external 1 Hz tick pulse, in either up or down direction. It adds lap hold, per-field adjust mode and a countdown-done flag. It sits between the tick/debounce logic and the seven-segment display driver.

## Interface
- `MIN_TENS_W`, default 3: width of the minutes-tens digit; must hold `MAX_MIN/10`.
- `MAX_MIN`, default 59: highest minutes value, legal range 1..99; the count wraps after `MAX_MIN:59`.
- `clk  in  1`: the single clock; all state is on its rising edge.
- `reset  in  1`: asynchronous, active-low reset.
- `tick  in  1`: 1 Hz count-enable pulse, one `clk` wide.
- `adj_tick  in  1`: adjust-rate pulse, one `clk` wide (2 Hz nominal).
- `pause_p  in  1`: debounced one-cycle pulse that toggles run/pause.
- `lap_p  in  1`: debounced one-cycle pulse that toggles lap hold.
- `adj  in  1`: level input; 1 selects adjust mode.
- `sel  in  1`: adjust field select; 1 = minutes, 0 = seconds.
- `down  in  1`: level input; 1 = count down (timer), 0 = count up.
- `min1  out  MIN_TENS_W`: displayed minutes tens.
- `min2  out  4`: displayed minutes ones.
- `sec1  out  3`: displayed seconds tens.
- `sec2  out  4`: displayed seconds ones.
- `running  out  1`: high while the FSM is in RUN.
- `done  out  1`: countdown reached 00:00.
- `wrap  out  1`: one-cycle pulse on up-count wrap.

## Operation
- **Reset state (`reset`=0):** count = 00:00, FSM = RUN, hold = 0, `done` = 0, `wrap` = 0. All displayed digits are 0 and `running` = 1. Reset is asynchronous and overrides everything, including mid-count and mid-adjust.
- **FSM states:** RUN, PAUSED, ADJUST.
  - RUN → PAUSED on `pause_p`.
  - PAUSED → RUN on `pause_p`.
  - Any state → ADJUST while `adj`=1; `pause_p` is ignored in ADJUST.
  - ADJUST → PAUSED when `adj` falls.
- **Up count (RUN, `tick`, `down`=0):**
  - `sec2` 9→0 carries into `sec1`; `sec1` 5→0 carries into the minutes.
  - Minutes 9→0 on the ones digit carries into the tens digit.
  - `MAX_MIN:59` → 00:00 with `wrap` pulsed for one cycle; counting continues.
- **Down count (RUN, `tick`, `down`=1):**
  - BCD borrow chain, the mirror of up count.
  - On the tick that lands on 00:00: set `done`, FSM → PAUSED.
  - A tick at 00:00 has no effect and never underflows.
- **Clearing `done`:** on any count change away from 00:00, or on reset.
- **Adjust (ADJUST, `adj_tick`):** increments only the field chosen by `sel`.
  - Seconds 59→00, with no carry into minutes.
  - Minutes `MAX_MIN`→00.
  - `down` is ignored in ADJUST; `tick` is ignored outside RUN.
- **Lap:** `lap_p` toggles hold in RUN or PAUSED; it is ignored in ADJUST.
  - Hold 0→1 snapshots the live count into the lap registers. Outputs show the snapshot while the live count continues.
  - Hold 1→0 switches the outputs back to the live count.
  - Entering ADJUST forces hold = 0.
- **Simultaneous events:**
  - `tick` and `pause_p` in RUN: the count advances, then the FSM goes to PAUSED.
  - `tick` and `lap_p`: the snapshot captures the pre-tick value.
  - `adj` rising and `tick` in the same cycle: the tick is dropped.
- **Invariant:** every digit stays within its legal BCD range at all times. Minutes never exceed `MAX_MIN`.

## Timing
- All outputs are registered.
- Count changes are visible one `clk` after the `tick`/`adj_tick` cycle.
- `done` and `running` update in the same cycle as the count that causes them.
- `wrap` is high exactly one cycle, aligned with the 00:00 output.
- Lap mux select is registered: the snapshot appears on the outputs one cycle after `lap_p`.
- No multi-cycle paths; the carry chain is single-cycle combinational.

## Structure
- **Shared package `stopwatch_pkg`:**
  - FSM state encoding (RUN, PAUSED, ADJUST).
  - Digit maxima (`SEC_ONES_MAX`=9, `SEC_TENS_MAX`=5, `MIN_ONES_MAX`=9).
  - Function computing minute tens/ones limits from `MAX_MIN`.
- **Sub-module `bcd_digit`**, instantiated four times:
  - Parameters: modulus and width.
  - Inputs: `inc`, `dec`, `clr`, `lim`.
  - Outputs: `carry` and `borrow`.
- **Top level:** FSM, carry-chain enables, lap snapshot registers and output mux.

## Test plan
- **Reset then up-count:** release `reset`, issue 75 `tick`s → 01:15, `running`=1; assert `reset`=0 mid-run → all outputs 0 asynchronously.
- **Wrap:** default params, preload via adjust to 59:58, 2 `tick`s in RUN → 59:59 then 00:00 with `wrap` high for one cycle.
- **Countdown:**
  - Adjust to 00:03, release `adj`, `pause_p` → RUN with `down`=1.
  - 3 `tick`s → 00:00, `done`=1, `running`=0.
  - A 4th tick leaves 00:00.
- **Adjust:** `adj`=1, `sel`=0, 61 `adj_tick`s from 00:00 → 00:01 with minutes untouched; `sel`=1, 3 `adj_tick`s → 03:01.
- **Lap:** at 00:10 `lap_p`, 5 `tick`s → outputs hold 00:10; `lap_p` → 00:15 next cycle.
- **Simultaneous:** `tick` and `pause_p` in the same cycle at 00:20 → 00:21, PAUSED; further `tick`s → no change.
